// File: rtl/corevx_ptw_pkg.sv
// Shared definitions for the corevx MMU page table walker: Sv32 field widths,
// PTE bit positions, Avalon response codes, PTW state encoding and the TLB
// command codes consumed by corevx_tlb.
package corevx_ptw_pkg;

    // Field widths
    localparam int unsigned VPN_W     = 20;
    localparam int unsigned VPN_SEG_W = 10;
    localparam int unsigned PPN_W     = 22;
    localparam int unsigned PTE_WIDTH = 32;
    localparam int unsigned PADDR_W   = 34;
    localparam int unsigned ABITS_W   = 8;
    localparam int unsigned RESP_W    = 2;

    // PTE bit positions
    localparam int unsigned PTE_BIT_V = 0;
    localparam int unsigned PTE_BIT_R = 1;
    localparam int unsigned PTE_BIT_W = 2;
    localparam int unsigned PTE_BIT_X = 3;
    localparam int unsigned PTE_BIT_U = 4;
    localparam int unsigned PTE_BIT_G = 5;
    localparam int unsigned PTE_BIT_A = 6;
    localparam int unsigned PTE_BIT_D = 7;

    // PTE PPN field and its two Sv32 segments
    localparam int unsigned PTE_PPN_MSB  = 31;
    localparam int unsigned PTE_PPN_LSB  = 10;
    localparam int unsigned PTE_PPN1_LSB = 20;
    localparam int unsigned PTE_PPN0_MSB = 19;

    // Avalon response codes
    localparam logic [RESP_W-1:0] AVL_RESP_OK        = 2'b00;
    localparam logic [RESP_W-1:0] AVL_RESP_RESERVED  = 2'b01;
    localparam logic [RESP_W-1:0] AVL_RESP_SLVERR    = 2'b10;
    localparam logic [RESP_W-1:0] AVL_RESP_DECODEERR = 2'b11;

    // Access bits reported for bare-mode translations (D A - - X W R V)
    localparam logic [ABITS_W-1:0] BARE_ACCESS_BITS = 8'hCF;

    // PTW state encoding
    typedef enum logic [1:0] {
        PTW_IDLE = 2'd0,
        PTW_READ = 2'd1,
        PTW_WAIT = 2'd2,
        PTW_DONE = 2'd3
    } ptw_state_e;

    // TLB command codes used by corevx_tlb
    localparam logic [1:0] TLB_CMD_NOP       = 2'd0;
    localparam logic [1:0] TLB_CMD_WRITE     = 2'd1;
    localparam logic [1:0] TLB_CMD_FLUSH_VA  = 2'd2;
    localparam logic [1:0] TLB_CMD_FLUSH_ALL = 2'd3;

endpackage

// File: rtl/corevx_ptw_pte_check.sv
// Combinational classification of a PTE returned by the walker's read.
// Ports:
//   pte         in  32  PTE read from memory
//   level       in  1   walk level the PTE was fetched at (1 = root)
//   response    in  2   Avalon response for the read
//   is_leaf     out 1   PTE grants R or X
//   pagefault   out 1   invalid, reserved W-only, misaligned superpage or level-0 pointer
//   accessfault out 1   bus error; takes priority over pagefault
//   misaligned  out 1   level-1 leaf with nonzero PPN[0]
module corevx_ptw_pte_check
    import corevx_ptw_pkg::*;
(
    input  logic [PTE_WIDTH-1:0] pte,
    input  logic                 level,
    input  logic [RESP_W-1:0]    response,
    output logic                 is_leaf,
    output logic                 pagefault,
    output logic                 accessfault,
    output logic                 misaligned
);

    logic invalid;
    logic unused_pte;

    assign accessfault = (response != AVL_RESP_OK);
    assign is_leaf     = pte[PTE_BIT_R] | pte[PTE_BIT_X];
    assign invalid     = ~pte[PTE_BIT_V] | (~pte[PTE_BIT_R] & pte[PTE_BIT_W]);
    assign misaligned  = is_leaf & level & (pte[PTE_PPN0_MSB:PTE_PPN_LSB] != '0);

    // A pointer at level 0 has nowhere left to go.
    assign pagefault   = ~accessfault & (invalid | misaligned | (~is_leaf & ~level));

    // PPN[1], RSW and U/G/A/D do not affect the classification.
    assign unused_pte  = ^{pte[PTE_PPN_MSB:PTE_PPN1_LSB], pte[PTE_BIT_D+2:PTE_BIT_U]};

endmodule

// File: rtl/corevx_ptw.sv
// Sv32 hardware page table walker. Resolves a TLB miss by reading one or two
// PTEs over an Avalon read master and reports PPN + access bits or a fault.
// Ports:
//   clk, rst_n                     clock, asynchronous active-high reset
//   resolve_request/virtual_address/satp_mode/satp_ppn   walk request (IDLE only)
//   resolve_done                   one-cycle completion pulse
//   resolve_pagefault/accessfault  fault flags, valid with done
//   resolve_physical_address       22-bit PPN, held until next completion
//   resolve_access_bits            PTE[7:0] of the last PTE read
//   avl_*                          Avalon read master (one read outstanding)
module corevx_ptw
    import corevx_ptw_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 resolve_request,
    input  logic [VPN_W-1:0]     virtual_address,
    input  logic                 satp_mode,
    input  logic [PPN_W-1:0]     satp_ppn,
    output logic                 resolve_done,
    output logic                 resolve_pagefault,
    output logic                 resolve_accessfault,
    output logic [PPN_W-1:0]     resolve_physical_address,
    output logic [ABITS_W-1:0]   resolve_access_bits,
    output logic [PADDR_W-1:0]   avl_address,
    output logic                 avl_read,
    input  logic                 avl_waitrequest,
    input  logic                 avl_readdatavalid,
    input  logic [PTE_WIDTH-1:0] avl_readdata,
    input  logic [RESP_W-1:0]    avl_response
);

    ptw_state_e             state_q;
    logic                   level_q;
    logic [VPN_SEG_W-1:0]   vpn0_q;

    logic chk_is_leaf;
    logic chk_pagefault;
    logic chk_accessfault;
    logic chk_misaligned;

    corevx_ptw_pte_check u_pte_check (
        .pte         (avl_readdata),
        .level       (level_q),
        .response    (avl_response),
        .is_leaf     (chk_is_leaf),
        .pagefault   (chk_pagefault),
        .accessfault (chk_accessfault),
        .misaligned  (chk_misaligned)
    );

    // Walk FSM with registered outputs; reset is active-high despite the name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q                  <= PTW_IDLE;
            level_q                  <= 1'b0;
            vpn0_q                   <= '0;
            resolve_done             <= 1'b0;
            resolve_pagefault        <= 1'b0;
            resolve_accessfault      <= 1'b0;
            resolve_physical_address <= '0;
            resolve_access_bits      <= '0;
            avl_address              <= '0;
            avl_read                 <= 1'b0;
        end else begin
            resolve_done <= 1'b0;
            case (state_q)
                PTW_IDLE: begin
                    if (resolve_request) begin
                        vpn0_q              <= virtual_address[VPN_SEG_W-1:0];
                        resolve_pagefault   <= 1'b0;
                        resolve_accessfault <= 1'b0;
                        if (!satp_mode) begin
                            resolve_physical_address <= {2'b00, virtual_address};
                            resolve_access_bits      <= BARE_ACCESS_BITS;
                            resolve_done             <= 1'b1;
                            state_q                  <= PTW_DONE;
                        end else begin
                            level_q     <= 1'b1;
                            avl_address <= {satp_ppn, virtual_address[VPN_W-1:VPN_SEG_W], 2'b00};
                            avl_read    <= 1'b1;
                            state_q     <= PTW_READ;
                        end
                    end
                end
                PTW_READ: begin
                    if (!avl_waitrequest) begin
                        avl_read <= 1'b0;
                        state_q  <= PTW_WAIT;
                    end
                end
                PTW_WAIT: begin
                    if (avl_readdatavalid) begin
                        resolve_access_bits <= avl_readdata[ABITS_W-1:0];
                        if (chk_accessfault || chk_pagefault) begin
                            resolve_accessfault      <= chk_accessfault;
                            resolve_pagefault        <= chk_pagefault;
                            resolve_physical_address <= '0;
                            resolve_done             <= 1'b1;
                            state_q                  <= PTW_DONE;
                        end else if (chk_is_leaf) begin
                            // Level-1 leaf is a 4 MiB superpage: low PPN comes from the VPN.
                            resolve_physical_address <= level_q
                                ? {avl_readdata[PTE_PPN_MSB:PTE_PPN1_LSB], vpn0_q}
                                : avl_readdata[PTE_PPN_MSB:PTE_PPN_LSB];
                            resolve_done             <= 1'b1;
                            state_q                  <= PTW_DONE;
                        end else begin
                            level_q     <= 1'b0;
                            avl_address <= {avl_readdata[PTE_PPN_MSB:PTE_PPN_LSB], vpn0_q, 2'b00};
                            avl_read    <= 1'b1;
                            state_q     <= PTW_READ;
                        end
                    end
                end
                PTW_DONE: begin
                    state_q <= PTW_IDLE;
                end
                default: begin
                    state_q <= PTW_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corevx_ptw.sv
// Directed testbench for corevx_ptw: a scripted Avalon slave answers each
// read with a hand-chosen PTE, and every outcome is compared against
// hand-computed latency, PPN, access bits and fault flags.
module tb_corevx_ptw;

    logic        clk;
    logic        rst_n;
    logic        resolve_request;
    logic [19:0] virtual_address;
    logic        satp_mode;
    logic [21:0] satp_ppn;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_access_bits;
    logic [33:0] avl_address;
    logic        avl_read;
    logic        avl_waitrequest;
    logic        avl_readdatavalid;
    logic [31:0] avl_readdata;
    logic [1:0]  avl_response;

    int n_checks = 0;
    int n_errors = 0;

    corevx_ptw u_dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .resolve_request          (resolve_request),
        .virtual_address          (virtual_address),
        .satp_mode                (satp_mode),
        .satp_ppn                 (satp_ppn),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_physical_address (resolve_physical_address),
        .resolve_access_bits      (resolve_access_bits),
        .avl_address              (avl_address),
        .avl_read                 (avl_read),
        .avl_waitrequest          (avl_waitrequest),
        .avl_readdatavalid        (avl_readdatavalid),
        .avl_readdata             (avl_readdata),
        .avl_response             (avl_response)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and play the Avalon slave until done (or timeout).
    // Inputs change and outputs are sampled at the falling edge.
    task automatic do_walk(
        input string       tag,
        input logic        mode,
        input logic [21:0] ppn,
        input logic [19:0] vpn,
        input int          npte,
        input int          ws,
        input logic [31:0] pte_a,
        input logic [1:0]  resp_a,
        input logic [33:0] addr_a,
        input logic [31:0] pte_b,
        input logic [33:0] addr_b,
        input int          exp_lat,
        input logic        exp_pf,
        input logic        exp_af,
        input logic [21:0] exp_phys,
        input logic [7:0]  exp_bits
    );
        int cyc;
        int idx;
        int wcnt;
        bit pending;
        bit done_seen;
        resolve_request = 1'b1;
        virtual_address = vpn;
        satp_mode       = mode;
        satp_ppn        = ppn;
        @(negedge clk);
        resolve_request = 1'b0;
        cyc       = 1;
        idx       = 0;
        wcnt      = 0;
        pending   = 1'b0;
        done_seen = 1'b0;
        while (!done_seen && cyc <= 40) begin
            avl_readdatavalid = 1'b0;
            avl_waitrequest   = 1'b0;
            if (resolve_done) begin
                done_seen = 1'b1;
                check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
                check_eq({tag, "_pagefault"}, 64'(resolve_pagefault), 64'(exp_pf));
                check_eq({tag, "_accessfault"}, 64'(resolve_accessfault), 64'(exp_af));
                if (!exp_pf && !exp_af) begin
                    check_eq({tag, "_phys"}, 64'(resolve_physical_address), 64'(exp_phys));
                    check_eq({tag, "_bits"}, 64'(resolve_access_bits), 64'(exp_bits));
                end
            end else if (pending) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = (idx == 0) ? pte_a : pte_b;
                avl_response      = (idx == 0) ? resp_a : 2'b00;
                pending           = 1'b0;
                idx++;
                wcnt              = 0;
            end else if (avl_read) begin
                if (idx >= npte) begin
                    check_eq({tag, "_extra_read"}, 64'(avl_read), 64'(0));
                end else begin
                    check_eq({tag, "_addr"}, 64'(avl_address), 64'((idx == 0) ? addr_a : addr_b));
                end
                if (wcnt < ws) begin
                    avl_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    pending = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        avl_readdatavalid = 1'b0;
        avl_waitrequest   = 1'b0;
        avl_response      = 2'b00;
        if (!done_seen) begin
            check_eq({tag, "_timeout"}, 64'(0), 64'(1));
        end else begin
            check_eq({tag, "_reads"}, 64'(idx), 64'(npte));
            check_eq({tag, "_done_pulse"}, 64'(resolve_done), 64'(0));
        end
    endtask

    initial begin
        resolve_request   = 1'b0;
        virtual_address   = '0;
        satp_mode         = 1'b0;
        satp_ppn          = '0;
        avl_waitrequest   = 1'b0;
        avl_readdatavalid = 1'b0;
        avl_readdata      = '0;
        avl_response      = 2'b00;
        rst_n             = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        check_eq("rst_avl_read", 64'(avl_read), 64'(0));
        check_eq("rst_avl_address", 64'(avl_address), 64'(0));
        check_eq("rst_done", 64'(resolve_done), 64'(0));
        check_eq("rst_pagefault", 64'(resolve_pagefault), 64'(0));
        check_eq("rst_accessfault", 64'(resolve_accessfault), 64'(0));
        check_eq("rst_phys", 64'(resolve_physical_address), 64'(0));
        check_eq("rst_bits", 64'(resolve_access_bits), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);

        // Two-level walk: pointer 0x2001 -> PPN 0x8; leaf PPN 0x3D4FF>>10 = 0xF5.
        do_walk("two_level", 1'b1, 22'h100, 20'h00055, 2, 0,
                32'h0000_2001, 2'b00, 34'h0_0010_0000,
                32'h0003_D4FF, 34'h0_0000_8154,
                5, 1'b0, 1'b0, 22'h0000F5, 8'hFF);

        // Superpage: PPN[1]=0x001, VPN[0]=0x101 -> {12'h001,10'h101} = 0x501.
        do_walk("superpage", 1'b1, 22'h100, 20'h00101, 1, 0,
                32'h0010_00CF, 2'b00, 34'h0_0010_0000,
                32'h0, 34'h0,
                3, 1'b0, 1'b0, 22'h000501, 8'hCF);

        // Superpage with nonzero PPN[0] is misaligned.
        do_walk("misaligned", 1'b1, 22'h100, 20'h00101, 1, 0,
                32'h0010_04CF, 2'b00, 34'h0_0010_0000,
                32'h0, 34'h0,
                3, 1'b1, 1'b0, 22'h0, 8'h0);

        do_walk("invalid_pte", 1'b1, 22'h100, 20'h00055, 1, 0,
                32'h0000_0000, 2'b00, 34'h0_0010_0000,
                32'h0, 34'h0,
                3, 1'b1, 1'b0, 22'h0, 8'h0);

        do_walk("w_without_r", 1'b1, 22'h100, 20'h00055, 1, 0,
                32'h0000_0005, 2'b00, 34'h0_0010_0000,
                32'h0, 34'h0,
                3, 1'b1, 1'b0, 22'h0, 8'h0);

        // Bus error on an otherwise valid leaf: accessfault only.
        do_walk("bus_error", 1'b1, 22'h100, 20'h00101, 1, 0,
                32'h0010_00CF, 2'b10, 34'h0_0010_0000,
                32'h0, 34'h0,
                3, 1'b0, 1'b1, 22'h0, 8'h0);

        do_walk("ptr_level0", 1'b1, 22'h100, 20'h00055, 2, 0,
                32'h0000_2001, 2'b00, 34'h0_0010_0000,
                32'h0000_2001, 34'h0_0000_8154,
                5, 1'b1, 1'b0, 22'h0, 8'h0);

        // Three wait states: address rechecked every stalled cycle, done at 3+3.
        do_walk("waitreq3", 1'b1, 22'h100, 20'h00101, 1, 3,
                32'h0010_00CF, 2'b00, 34'h0_0010_0000,
                32'h0, 34'h0,
                6, 1'b0, 1'b0, 22'h000501, 8'hCF);

        // All-ones root PPN and VPN[1]: address 34'h3_FFFF_FFFC; leaf {12'h800,10'h001}.
        do_walk("max_addr", 1'b1, 22'h3FFFFF, 20'hFFC01, 1, 0,
                32'h8000_000F, 2'b00, 34'h3_FFFF_FFFC,
                32'h0, 34'h0,
                3, 1'b0, 1'b0, 22'h200001, 8'h0F);

        do_walk("bare", 1'b0, 22'h100, 20'hABCDE, 0, 0,
                32'h0, 2'b00, 34'h0,
                32'h0, 34'h0,
                1, 1'b0, 1'b0, 22'h0ABCDE, 8'hCF);

        // Reset in WAIT, stale readdatavalid afterwards, then a clean walk.
        resolve_request = 1'b1;
        satp_mode       = 1'b1;
        satp_ppn        = 22'h100;
        virtual_address = 20'h00055;
        @(negedge clk);
        resolve_request = 1'b0;
        check_eq("rstwalk_read", 64'(avl_read), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rstwalk_avl_read", 64'(avl_read), 64'(0));
        check_eq("rstwalk_avl_address", 64'(avl_address), 64'(0));
        check_eq("rstwalk_done", 64'(resolve_done), 64'(0));
        check_eq("rstwalk_phys", 64'(resolve_physical_address), 64'(0));
        @(negedge clk);
        rst_n             = 1'b0;
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'h0010_00CF;
        avl_response      = 2'b00;
        repeat (2) begin
            @(negedge clk);
            check_eq("stale_done", 64'(resolve_done), 64'(0));
            check_eq("stale_read", 64'(avl_read), 64'(0));
            check_eq("stale_bits", 64'(resolve_access_bits), 64'(0));
        end
        avl_readdatavalid = 1'b0;
        do_walk("after_reset", 1'b1, 22'h100, 20'h00055, 2, 0,
                32'h0000_2001, 2'b00, 34'h0_0010_0000,
                32'h0003_D4FF, 34'h0_0000_8154,
                5, 1'b0, 1'b0, 22'h0000F5, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
